// File: rtl/serial_sub_4bit.sv
// Bit-serial two's-complement subtractor: Diff = A - B, one bit per clock, LSB first.
// Optional signed-overflow output and its logic are enabled by defining SUB_OVF_EN.
module serial_sub_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Zero
`ifdef SUB_OVF_EN
  ,output logic            Ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // One full-subtractor cell: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bin);
    logic d;
    logic bo;
    d  = a ^ b ^ bin;
    bo = (~a & b) | (~(a ^ b) & bin);
    return {bo, d};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;
`ifdef SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  logic             d_bit_s;
  logic             borrow_next_s;
  logic [WIDTH-1:0] res_shift_s;

  // Next-state and next-output computation for the serial datapath.
  always_comb begin
    state_d  = state_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    zero_d   = zero_q;
`ifdef SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif

    {borrow_next_s, d_bit_s} = full_sub(ra_q[0], rb_q[0], borrow_q);
    res_shift_s = {d_bit_s, res_q[WIDTH-1:1]};

    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (start) begin
          state_d  = S_SHIFT;
          ra_d     = A;
          rb_d     = B;
          res_d    = {WIDTH{1'b0}};
          borrow_d = 1'b0;
          cnt_d    = {CW{1'b0}};
          busy_d   = 1'b1;
`ifdef SUB_OVF_EN
          a_msb_d  = A[WIDTH-1];
          b_msb_d  = B[WIDTH-1];
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        ra_d     = ra_q >> 1;
        rb_d     = rb_q >> 1;
        res_d    = res_shift_s;
        borrow_d = borrow_next_s;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          diff_d  = res_shift_s;
          bout_d  = borrow_next_s;
          zero_d  = (res_shift_s == {WIDTH{1'b0}});
`ifdef SUB_OVF_EN
          ovf_d   = (a_msb_q ^ b_msb_q) & (res_shift_s[WIDTH-1] ^ a_msb_q);
`endif
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        // The edge leaving DONE is also the earliest acceptance edge (WIDTH+1 cycle throughput).
        done_d = 1'b0;
        if (start) begin
          state_d  = S_SHIFT;
          ra_d     = A;
          rb_d     = B;
          res_d    = {WIDTH{1'b0}};
          borrow_d = 1'b0;
          cnt_d    = {CW{1'b0}};
          busy_d   = 1'b1;
`ifdef SUB_OVF_EN
          a_msb_d  = A[WIDTH-1];
          b_msb_d  = B[WIDTH-1];
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ra_q     <= {WIDTH{1'b0}};
      rb_q     <= {WIDTH{1'b0}};
      res_q    <= {WIDTH{1'b0}};
      borrow_q <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= {WIDTH{1'b0}};
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
`ifdef SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
`ifdef SUB_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Diff = diff_q;
  assign Bout = bout_q;
  assign Zero = zero_q;
`ifdef SUB_OVF_EN
  assign Ovf  = ovf_q;
`endif

endmodule
